// File: rtl/alu_sequencer.sv
// Instruction FIFO plus run controller that drives a combinational 4-bit ALU.
// Each queued (sel, B) pair is applied to the accumulator, and the ALU result is written back.
module alu_sequencer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_sel,
    input  logic [3:0] instr_b,
    input  logic       start,
    input  logic [3:0] init_a,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    output logic [3:0] acc,
    output logic       busy,
    output logic       done,
    output logic [7:0] exec_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

    state_t          state_q, state_d;
    logic [6:0]      mem_q [DEPTH];
    logic [6:0]      mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [3:0]      acc_q, acc_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic [2:0]      alu_sel_q, alu_sel_d;
    logic [7:0]      exec_cnt_q, exec_cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            push_s;
    logic            pop_s;
    logic            fifo_empty_s;
    logic [6:0]      head_s;

    assign instr_ready  = (count_q != FULL_CNT);
    assign push_s       = instr_valid && instr_ready;
    assign pop_s        = (state_q == ISSUE);
    assign fifo_empty_s = (count_q == {CW{1'b0}});
    assign head_s       = mem_q[rd_ptr_q];

    // FIFO storage, pointer and occupancy update
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {instr_sel, instr_b};
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Run FSM: next state and datapath register updates
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        exec_cnt_d = exec_cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d      = init_a;
                    exec_cnt_d = 8'd0;
                    state_d    = fifo_empty_s ? DONE : ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                alu_a_d   = acc_q;
                alu_b_d   = head_s[3:0];
                alu_sel_d = head_s[6:4];
                state_d   = CAPTURE;
            end
            CAPTURE: begin
                acc_d      = alu_result;
                exec_cnt_d = exec_cnt_q + 8'd1;
                state_d    = fifo_empty_s ? DONE : ISSUE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Status flags are registered copies of the next-state decode
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, FIFO and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            count_q    <= {CW{1'b0}};
            acc_q      <= 4'd0;
            alu_a_q    <= 4'd0;
            alu_b_q    <= 4'd0;
            alu_sel_q  <= 3'd0;
            exec_cnt_q <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 7'd0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_sel_q  <= alu_sel_d;
            exec_cnt_q <= exec_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_q      <= mem_d;
        end
    end

    assign acc      = acc_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_sel  = alu_sel_q;
    assign exec_cnt = exec_cnt_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU is attached, and a queue-based program model
// predicts the issued operands, accumulator, counters and the done/busy timing.
module tb_alu_sequencer;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_sel;
    logic [3:0] instr_b;
    logic       start;
    logic [3:0] init_a;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic [3:0] acc;
    logic       busy;
    logic       done;
    logic [7:0] exec_cnt;

    typedef struct packed {
        logic [2:0] sel;
        logic [3:0] b;
    } instr_t;

    instr_t     mq[$];
    logic [3:0] m_acc;
    logic [3:0] m_a;
    logic [3:0] m_b;
    logic [2:0] m_sel;
    logic [7:0] m_cnt;
    int         checks = 0;
    int         errors = 0;

    function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return a << 1;
            3'd6:    return a >> 1;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_sel);

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_sel   (instr_sel),
        .instr_b     (instr_b),
        .start       (start),
        .init_a      (init_a),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_result  (alu_result),
        .acc         (acc),
        .busy        (busy),
        .done        (done),
        .exec_cnt    (exec_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] s, input logic [3:0] b);
        bit ok;
        ok          = (mq.size() < DEPTH);
        instr_valid = 1'b1;
        instr_sel   = s;
        instr_b     = b;
        chk("push_ready", 8'(instr_ready), 8'(ok));
        tick();
        instr_valid = 1'b0;
        if (ok) mq.push_back({s, b});
    endtask

    // hk_kind: 0 none, 1 push during ISSUE of instr hk_k, 2 push during its CAPTURE, 3 start during its CAPTURE
    task automatic run(input logic [3:0] init, input int hk_k, input int hk_kind,
                       input logic [2:0] hs, input logic [3:0] hb);
        int     k;
        bit     ok;
        instr_t cur;
        start  = 1'b1;
        init_a = init;
        tick();
        start  = 1'b0;
        init_a = ~init;
        m_acc  = init;
        m_cnt  = 8'd0;
        chk("start_busy", 8'(busy), 8'd1);
        chk("start_acc", 8'(acc), 8'(m_acc));
        chk("start_cnt", exec_cnt, 8'd0);
        chk("start_done", 8'(done), 8'(mq.size() == 0));
        k = 0;
        while (mq.size() > 0 && k < 64) begin
            ok = 1'b0;
            if (k == hk_k && hk_kind == 1) begin
                ok          = (mq.size() < DEPTH);
                instr_valid = 1'b1;
                instr_sel   = hs;
                instr_b     = hb;
                chk("issue_ready", 8'(instr_ready), 8'(ok));
            end
            tick();
            instr_valid = 1'b0;
            cur   = mq.pop_front();
            if (ok) mq.push_back({hs, hb});
            m_a   = m_acc;
            m_b   = cur.b;
            m_sel = cur.sel;
            chk("issue_a", 8'(alu_a), 8'(m_a));
            chk("issue_b", 8'(alu_b), 8'(m_b));
            chk("issue_sel", 8'(alu_sel), 8'(m_sel));
            chk("issue_done", 8'(done), 8'd0);
            chk("issue_busy", 8'(busy), 8'd1);
            ok = 1'b0;
            if (k == hk_k && hk_kind == 2) begin
                ok          = (mq.size() < DEPTH);
                instr_valid = 1'b1;
                instr_sel   = hs;
                instr_b     = hb;
            end
            if (k == hk_k && hk_kind == 3) begin
                start  = 1'b1;
                init_a = hb;
            end
            tick();
            instr_valid = 1'b0;
            start       = 1'b0;
            m_acc = alu_f(m_a, m_b, m_sel);
            m_cnt = m_cnt + 8'd1;
            if (ok) mq.push_back({hs, hb});
            chk("cap_acc", 8'(acc), 8'(m_acc));
            chk("cap_cnt", exec_cnt, m_cnt);
            chk("cap_done", 8'(done), 8'(mq.size() == 0));
            k++;
        end
        tick();
        chk("end_done", 8'(done), 8'd0);
        chk("end_busy", 8'(busy), 8'd0);
        chk("end_acc", 8'(acc), 8'(m_acc));
        chk("end_cnt", exec_cnt, m_cnt);
        chk("hold_a", 8'(alu_a), 8'(m_a));
        chk("hold_b", 8'(alu_b), 8'(m_b));
        chk("hold_sel", 8'(alu_sel), 8'(m_sel));
        chk("end_ready", 8'(instr_ready), 8'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_sel   = 3'd0;
        instr_b     = 4'd0;
        start       = 1'b0;
        init_a      = 4'd0;
        m_acc = 4'd0; m_a = 4'd0; m_b = 4'd0; m_sel = 3'd0; m_cnt = 8'd0;
        #2;
        chk("rst_acc", 8'(acc), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_done", 8'(done), 8'd0);
        chk("rst_ready", 8'(instr_ready), 8'd1);
        chk("rst_alu_a", 8'(alu_a), 8'd0);
        chk("rst_cnt", exec_cnt, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full program over every opcode
        push(3'b000, 4'd1); push(3'b001, 4'd1); push(3'b010, 4'd1); push(3'b011, 4'b0110);
        push(3'b100, 4'b0101); push(3'b101, 4'd9); push(3'b110, 4'd3); push(3'b111, 4'd12);
        run(4'b0011, -1, 0, 3'd0, 4'd0);
        chk("prog_acc", 8'(acc), 8'b0010);
        chk("prog_cnt", exec_cnt, 8'd8);

        // Empty start
        run(4'b1010, -1, 0, 3'd0, 4'd0);
        chk("empty_acc", 8'(acc), 8'b1010);

        // Full FIFO, dropped 9th push, then a second batch through wrapped pointers
        for (int i = 0; i < 8; i++) push(3'($urandom_range(0, 7)), 4'($urandom));
        push(3'd0, 4'd5);
        run(4'($urandom), -1, 0, 3'd0, 4'd0);
        for (int i = 0; i < 8; i++) push(3'($urandom_range(0, 7)), 4'($urandom));
        run(4'($urandom), -1, 0, 3'd0, 4'd0);

        // Mid-run push extends the run
        push(3'd0, 4'd1); push(3'd0, 4'd1);
        run(4'd0, 0, 2, 3'd0, 4'd1);
        chk("midrun_acc", 8'(acc), 8'b0011);
        chk("midrun_cnt", exec_cnt, 8'd3);

        // Start while busy is ignored
        push(3'd0, 4'd2); push(3'd3, 4'd8);
        run(4'd1, 0, 3, 3'd0, 4'hF);

        // Push coincident with pop: full FIFO rejects, partial FIFO accepts
        for (int i = 0; i < 8; i++) push(3'($urandom_range(0, 4)), 4'($urandom));
        run(4'd7, 0, 1, 3'd0, 4'd1);
        push(3'd0, 4'd3); push(3'd1, 4'd1); push(3'd4, 4'd6);
        run(4'd2, 0, 1, 3'd0, 4'd5);
        chk("pp_cnt", exec_cnt, 8'd4);

        // Random programs of varying length
        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push(3'($urandom_range(0, 7)), 4'($urandom));
            run(4'($urandom), -1, 0, 3'd0, 4'd0);
        end

        // Asynchronous reset during CAPTURE
        push(3'd0, 4'd1); push(3'd0, 4'd2); push(3'd0, 4'd3);
        start  = 1'b1;
        init_a = 4'd9;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_acc", 8'(acc), 8'd0);
        chk("arst_alu_a", 8'(alu_a), 8'd0);
        chk("arst_alu_b", 8'(alu_b), 8'd0);
        chk("arst_alu_sel", 8'(alu_sel), 8'd0);
        chk("arst_cnt", exec_cnt, 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_done", 8'(done), 8'd0);
        chk("arst_ready", 8'(instr_ready), 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst_hold_done", 8'(done), 8'd0);
        end
        rst_n = 1'b1;
        mq.delete();
        m_acc = 4'd0; m_a = 4'd0; m_b = 4'd0; m_sel = 3'd0; m_cnt = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_done", 8'(done), 8'd0);
        end
        chk("arst_rel_ready", 8'(instr_ready), 8'd1);
        run(4'd6, -1, 0, 3'd0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
